// File: rtl/eeprom_rw_test.sv
// EEPROM self test: writes a seeded byte pattern through an IIC driver, reads it back,
// and reports pass/fail together with a saturating count of mismatched bytes.
//
// state   | meaning
// IDLE    | waiting for start_i
// WR_REQ  | write request raised, held until the driver's scl4x acknowledge
// WR_WAIT | write in flight, waiting for iic_done rising edge
// WR_GAP  | EEPROM internal write cycle, fixed idle time
// RD_REQ  | read request raised, held until the driver's scl4x acknowledge
// RD_WAIT | read in flight, read data captured on iic_done rising edge
// CHECK   | compare captured byte against the pattern
// FINISH  | one-cycle result strobe
module eeprom_rw_test #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'b1010000,
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int unsigned BYTE_NUM    = 16,
    parameter logic [7:0]  DATA_SEED   = 8'hA5,
    parameter logic        BIT_SEL     = 1'b1,
    parameter int unsigned WR_GAP_CYC  = 250000,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        scl4x_i,
    input  logic        iic_done_i,
    input  logic [7:0]  iic_read_data_i,
    output logic        iic_en_o,
    output logic [6:0]  iic_slave_addr_o,
    output logic [15:0] iic_dev_addr_o,
    output logic        iic_bit_sel_o,
    output logic        iic_rh_wl_o,
    output logic [7:0]  iic_write_data_o,
    output logic        busy_o,
    output logic        test_done_o,
    output logic        test_pass_o,
    output logic [15:0] err_cnt_o
);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_WAIT, WR_GAP, RD_REQ, RD_WAIT, CHECK, FINISH
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(BYTE_NUM - 1);
    localparam logic [31:0] GAP_LOAD = 32'(WR_GAP_CYC - 1);
    localparam logic [31:0] TO_LOAD  = 32'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic [31:0] gap_q, gap_d;
    logic [31:0] to_q, to_d;
    logic [15:0] err_q, err_d;
    logic        pass_q, pass_d;
    logic        rh_wl_q, rh_wl_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        scl_q, done_q, enter_q;

    logic        scl_rise, done_rise, waiting, timeout;
    logic [7:0]  exp_byte;

    // Edges are not acted on in the first cycle of a state, so a level left over
    // from the previous transaction can never count as a fresh event.
    assign scl_rise  = scl4x_i & ~scl_q & ~enter_q;
    assign done_rise = iic_done_i & ~done_q & ~enter_q;
    assign waiting   = (state_q == WR_REQ) || (state_q == WR_WAIT) ||
                       (state_q == RD_REQ) || (state_q == RD_WAIT);
    assign timeout   = waiting && (to_q == '0);
    assign exp_byte  = idx_q[7:0] + DATA_SEED;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            gap_q     <= '0;
            to_q      <= '0;
            err_q     <= '0;
            pass_q    <= 1'b0;
            rh_wl_q   <= 1'b0;
            wr_data_q <= '0;
            rd_data_q <= '0;
            scl_q     <= 1'b0;
            done_q    <= 1'b0;
            enter_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            to_q      <= to_d;
            err_q     <= err_d;
            pass_q    <= pass_d;
            rh_wl_q   <= rh_wl_d;
            wr_data_q <= wr_data_d;
            rd_data_q <= rd_data_d;
            scl_q     <= scl4x_i;
            done_q    <= iic_done_i;
            enter_q   <= (state_d != state_q);
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        to_d      = to_q;
        err_d     = err_q;
        pass_d    = pass_q;
        rh_wl_d   = rh_wl_q;
        wr_data_d = wr_data_q;
        rd_data_d = rd_data_q;
        if (waiting && (to_q != '0)) begin
            to_d = to_q - 32'd1;
        end
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    idx_d   = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (scl_rise) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (done_rise) begin
                    gap_d   = GAP_LOAD;
                    state_d = WR_GAP;
                end
            end
            WR_GAP: begin
                if (gap_q == '0) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = RD_REQ;
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        state_d = WR_REQ;
                    end
                end else begin
                    gap_d = gap_q - 32'd1;
                end
            end
            RD_REQ: begin
                if (scl_rise) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (done_rise) begin
                    rd_data_d = iic_read_data_i;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                if ((rd_data_q != exp_byte) && (err_q != 16'hFFFF)) begin
                    err_d = err_q + 16'd1;
                end
                if (idx_q == LAST_IDX) begin
                    pass_d  = (err_d == 16'h0000);
                    state_d = FINISH;
                end else begin
                    idx_d   = idx_q + 16'd1;
                    state_d = RD_REQ;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            state_d = FINISH;
            err_d   = 16'hFFFF;
            pass_d  = 1'b0;
        end
        // Request attributes and the watchdog are loaded once per state entry.
        if (state_d != state_q) begin
            case (state_d)
                WR_REQ: begin
                    rh_wl_d   = 1'b0;
                    wr_data_d = idx_d[7:0] + DATA_SEED;
                    to_d      = TO_LOAD;
                end
                RD_REQ: begin
                    rh_wl_d = 1'b1;
                    to_d    = TO_LOAD;
                end
                WR_WAIT, RD_WAIT: to_d = TO_LOAD;
                default: ;
            endcase
        end
    end

    assign iic_en_o         = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign iic_slave_addr_o = SLAVE_ADDR;
    assign iic_dev_addr_o   = BASE_ADDR + idx_q;
    assign iic_bit_sel_o    = BIT_SEL;
    assign iic_rh_wl_o      = rh_wl_q;
    assign iic_write_data_o = wr_data_q;
    assign busy_o           = (state_q != IDLE);
    assign test_done_o      = (state_q == FINISH);
    assign test_pass_o      = pass_q;
    assign err_cnt_o        = err_q;

endmodule

// File: doc/eeprom_rw_test.md
EEPROM_RW_TEST -- requirements
Module: eeprom_rw_test

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'b1010000, IIC slave address driven to the driver.
REQ-002 SHALL have parameter BASE_ADDR, default 16'h0000, first device address tested.
REQ-003 SHALL have parameter BYTE_NUM, default 16, number of bytes written then read (1..65535).
REQ-004 SHALL have parameter DATA_SEED, default 8'hA5; byte i carries (i[7:0] + DATA_SEED) mod 256.
REQ-005 SHALL have parameter BIT_SEL, default 1'b1, device address width select (0: 8-bit, 1: 16-bit).
REQ-006 SHALL have parameter WR_GAP_CYC, default 250000, idle Clk cycles after each write (5 ms EEPROM write cycle at 50 MHz).
REQ-007 SHALL have parameter TIMEOUT_CYC, default 1000000, maximum Clk cycles spent waiting for one IIC_done.
REQ-008 Clk  input  1  system clock, 50 MHz.
REQ-009 Rst_n  input  1  asynchronous active-low reset.
REQ-010 Start  input  1  one-cycle pulse; starts a test run when idle.
REQ-011 Scl4x  input  1  driver's 4x-SCL tick; rising edge acknowledges IIC_en.
REQ-012 IIC_done  input  1  driver transaction complete; acted on at its rising edge.
REQ-013 IIC_read_data  input  8  byte returned by a read transaction.
REQ-014 IIC_en  output  1  transaction request to the driver.
REQ-015 IIC_slave_addr  output  7  equals SLAVE_ADDR, constant.
REQ-016 IIC_dev_addr  output  16  BASE_ADDR + current index, wrapping mod 2^16.
REQ-017 IIC_bit_sel  output  1  equals BIT_SEL, constant.
REQ-018 IIC_rh_wl  output  1  0 = write, 1 = read.
REQ-019 IIC_write_data  output  8  pattern byte for current index.
REQ-020 Busy  output  1  high from Start acceptance until Test_done.
REQ-021 Test_done  output  1  one-cycle pulse at run end.
REQ-022 Test_pass  output  1  run result; held until next accepted Start.
REQ-023 Err_cnt  output  16  count of mismatched read bytes, saturating at 16'hFFFF.

Function
REQ-024 SHALL implement states IDLE, WR_REQ, WR_WAIT, WR_GAP, RD_REQ, RD_WAIT, CHECK, FINISH.
REQ-025 IDLE: Start high -> clear index, Err_cnt, Test_pass; enter WR_REQ next cycle; Start in any other state is ignored.
REQ-026 WR_REQ/RD_REQ: IIC_en high, with IIC_rh_wl, IIC_dev_addr and IIC_write_data stable, until the first Clk cycle in which the registered Scl4x rising edge is detected; then IIC_en low and move to WR_WAIT/RD_WAIT.
REQ-027 IIC_dev_addr, IIC_rh_wl and IIC_write_data SHALL stay stable from WR_REQ/RD_REQ entry until the matching IIC_done edge.
REQ-028 WR_WAIT: on IIC_done rising edge -> WR_GAP; the gap counter counts WR_GAP_CYC cycles.
REQ-029 WR_GAP end: if index == BYTE_NUM-1, clear index and go to RD_REQ; otherwise increment index and go to WR_REQ.
REQ-030 RD_WAIT: on IIC_done rising edge, capture IIC_read_data in the same cycle and go to CHECK.
REQ-031 CHECK (1 cycle): on mismatch with the pattern byte, increment Err_cnt (saturating); if index == BYTE_NUM-1 go to FINISH, else increment index and go to RD_REQ (no gap).
REQ-032 FINISH (1 cycle): Test_done = 1, Test_pass = (Err_cnt == 0), Busy low next cycle; return to IDLE.
REQ-033 Timeout: in WR_REQ, WR_WAIT, RD_REQ or RD_WAIT, a cycle counter reset on state entry reaching TIMEOUT_CYC forces IIC_en low, Err_cnt = 16'hFFFF, and a jump to FINISH (Test_pass = 0).
REQ-034 An IIC_done rising edge outside WR_WAIT/RD_WAIT SHALL be ignored.
REQ-035 IIC_done edge detection and Scl4x edge detection SHALL use one register stage each; the first edge is detectable one cycle after entry to WR_WAIT/RD_WAIT or WR_REQ/RD_REQ respectively.

Reset
REQ-036 Rst_n low at any time SHALL asynchronously force state IDLE, IIC_en 0, IIC_rh_wl 0, IIC_dev_addr BASE_ADDR, IIC_write_data 0, Busy 0, Test_done 0, Test_pass 0, Err_cnt 0, and clear all counters and edge registers.
REQ-037 Reset mid-transaction SHALL abort the run with no Test_done; operation resumes only on a new Start.

Verification
REQ-038 BYTE_NUM=4, WR_GAP_CYC=20, behavioural EEPROM model, Start -> 4 writes to 0x0000..0x0003 with data A5,A6,A7,A8, then 4 reads; Test_done pulse, Test_pass=1, Err_cnt=0.
REQ-039 Same setup, model corrupts read byte at 0x0002 to 00 -> Test_pass=0, Err_cnt=1.
REQ-040 Model never asserts IIC_done, TIMEOUT_CYC=100 -> IIC_en low, Err_cnt=FFFF, Test_pass=0, Test_done 100-102 cycles after the request.
REQ-041 BASE_ADDR=16'hFFFE, BYTE_NUM=4 -> dev addresses FFFE, FFFF, 0000, 0001.
REQ-042 Rst_n pulsed low during the third write's WR_WAIT -> all outputs at reset values immediately, no Test_done; a new Start reruns from index 0.
REQ-043 Start pulsed while Busy -> ignored; the run completes unchanged, with exactly one Test_done.
